// File: rtl/counter_down_mod_if.sv
`default_nettype none
// ============================================================================
// Module      : counter_down_mod_if
// Description : Bundle of control and status signals for one counter_down_mod
//               stage.
//               master : enablen, load, in, hold -> stage
//               slave  : count, rco_L, zero (and done) <- stage
//               Optional macro COUNTER_DOWN_MOD_DONE_EN adds the done status.
// Revision    : 1.0 - initial release
// ============================================================================
interface counter_down_mod_if #(
    parameter int WIDTH = 4
);
    logic             enablen;   // active-low count enable
    logic             load;      // synchronous parallel load
    logic [WIDTH-1:0] in;        // parallel load value
    logic             hold;      // 1: stop at 0, 0: wrap
    logic [WIDTH-1:0] count;     // registered count
    logic             rco_L;     // active-low borrow out
    logic             zero;      // count == 0
`ifdef COUNTER_DOWN_MOD_DONE_EN
    logic             done;      // one-clock pulse after a 1 -> 0 decrement

    modport master (output enablen, load, in, hold,
                    input  count, rco_L, zero, done);
    modport slave  (input  enablen, load, in, hold,
                    output count, rco_L, zero, done);
`else
    modport master (output enablen, load, in, hold,
                    input  count, rco_L, zero);
    modport slave  (input  enablen, load, in, hold,
                    output count, rco_L, zero);
`endif
endinterface
`default_nettype wire

// File: rtl/counter_down_mod.sv
`default_nettype none
// ============================================================================
// Module      : counter_down_mod
// Description : Parametrised down-counter digit. Counts MODULUS-1 .. 0 on each
//               edge with enablen low, synchronous clamped parallel load,
//               optional hold-at-zero, combinational active-low borrow out.
//               Ports:
//                 clk  - clock, rising edge
//                 rst  - asynchronous reset, active low
//                 bus  - counter_down_mod_if.slave (controls + status)
//               Macro COUNTER_DOWN_MOD_DONE_EN adds the registered done pulse.
//               Legal parameters: 2 <= MODULUS <= 2**WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_down_mod #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 6
) (
    input  logic                clk,
    input  logic                rst,
    counter_down_mod_if.slave   bus
);
    // One extra bit so MODULUS == 2**WIDTH still compares correctly.
    localparam logic [WIDTH:0]   C_MOD = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] C_TOP = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next_count;
    logic             w_at_zero;

    assign w_at_zero = (r_count == '0);

    always_comb begin
        w_next_count = r_count;
        if (bus.load) begin
            // Out-of-range load values clamp to the top of the range.
            w_next_count = ({1'b0, bus.in} >= C_MOD) ? C_TOP : bus.in;
        end else if (!bus.enablen) begin
            if (!w_at_zero) begin
                w_next_count = r_count - WIDTH'(1);
            end else if (!bus.hold) begin
                w_next_count = C_TOP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_next_count;
        end
    end

    assign bus.count = r_count;
    assign bus.zero  = w_at_zero;
    // Borrow does not look at hold or load: upper stages must see it on the
    // same edge that this stage passes through zero.
    assign bus.rco_L = ~(w_at_zero & ~bus.enablen);

`ifdef COUNTER_DOWN_MOD_DONE_EN
    logic r_done;

    // Only a true decrement from 1 reaches 0 with load low and enable active,
    // so sitting at 0 in hold mode never re-fires.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= ~bus.load & ~bus.enablen & (r_count == WIDTH'(1));
        end
    end

    assign bus.done = r_done;
`endif

endmodule
`default_nettype wire

// File: tb/tb_counter_down_mod.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_counter_down_mod
// Description : Self-checking bench for counter_down_mod: single mod-6 stage
//               plus a mod-10 / mod-6 cascade, checked against an arithmetic
//               model every cycle and against hand-computed literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_down_mod;
    localparam int C_W   = 4;
    localparam int C_MOD = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    counter_down_mod_if #(.WIDTH(C_W)) u_bus ();
    counter_down_mod_if #(.WIDTH(C_W)) u_lo_bus ();
    counter_down_mod_if #(.WIDTH(C_W)) u_hi_bus ();

    counter_down_mod #(.WIDTH(C_W), .MODULUS(C_MOD)) u_dut (
        .clk (clk), .rst (rst), .bus (u_bus));
    counter_down_mod #(.WIDTH(C_W), .MODULUS(10)) u_lo (
        .clk (clk), .rst (rst), .bus (u_lo_bus));
    counter_down_mod #(.WIDTH(C_W), .MODULUS(6)) u_hi (
        .clk (clk), .rst (rst), .bus (u_hi_bus));

    assign u_hi_bus.enablen = u_lo_bus.rco_L;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_on  = 1'b0;

    int m_count;
    int m_prev;
    int m_done;
    int m_cas;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a single stage is a number in [0, MODULUS) stepped by
    // modular subtraction; the cascade is one number in [0, 60) stepped by 1.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_count = 0;
            m_done  = 0;
            m_cas   = 0;
        end else begin
            m_prev = m_count;
            if (u_bus.load)
                m_count = (int'(u_bus.in) >= C_MOD) ? C_MOD - 1 : int'(u_bus.in);
            else if (!u_bus.enablen && !(u_bus.hold && m_count == 0))
                m_count = (m_count + C_MOD - 1) % C_MOD;
            m_done = (!u_bus.load && m_prev == 1 && m_count == 0) ? 1 : 0;

            if (u_lo_bus.load)
                m_cas = 10 * int'(u_hi_bus.in) + int'(u_lo_bus.in);
            else if (!u_lo_bus.enablen)
                m_cas = (m_cas + 59) % 60;
        end
    end

    // Single compare process, sampling on the falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            check("model_count", int'(u_bus.count), m_count);
            check("model_zero",  int'(u_bus.zero), (m_count == 0) ? 1 : 0);
            check("model_rco_L", int'(u_bus.rco_L),
                  (m_count == 0 && !u_bus.enablen) ? 0 : 1);
`ifdef COUNTER_DOWN_MOD_DONE_EN
            check("model_done", int'(u_bus.done), m_done);
`endif
            check("model_cascade",
                  10 * int'(u_hi_bus.count) + int'(u_lo_bus.count), m_cas);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int v);
        u_bus.in   = C_W'(v);
        u_bus.load = 1'b1;
        tick();
        u_bus.load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        u_bus.enablen    = 1'b1;
        u_bus.load       = 1'b0;
        u_bus.in         = '0;
        u_bus.hold       = 1'b0;
        u_lo_bus.enablen = 1'b1;
        u_lo_bus.load    = 1'b0;
        u_lo_bus.in      = '0;
        u_lo_bus.hold    = 1'b0;
        u_hi_bus.load    = 1'b0;
        u_hi_bus.in      = '0;
        u_hi_bus.hold    = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_count", int'(u_bus.count), 0);
        check("rst_zero",  int'(u_bus.zero), 1);
        check("rst_rco_L", int'(u_bus.rco_L), 1);
        rst    = 1'b1;
        chk_on = 1'b1;

        // Clamp load
        do_load(9);  check("clamp_9", int'(u_bus.count), 5);
        do_load(5);  check("load_5",  int'(u_bus.count), 5);
        do_load(3);  check("load_3",  int'(u_bus.count), 3);

        // Asynchronous reset mid-count, seen before the next edge
        #2 rst = 1'b0;
        #1;
        check("arst_count", int'(u_bus.count), 0);
        check("arst_zero",  int'(u_bus.zero), 1);
        check("arst_rco_L_en1", int'(u_bus.rco_L), 1);
        u_bus.enablen = 1'b0;
        #2;
        check("arst_rco_L_en0", int'(u_bus.rco_L), 0);
        u_bus.enablen = 1'b1;
        tick();
        check("arst_hold_low", int'(u_bus.count), 0);
        rst = 1'b1;

        // Wrap with borrow
        u_bus.hold    = 1'b0;
        u_bus.enablen = 1'b0;
        do_load(1);
        check("wrap_1",       int'(u_bus.count), 1);
        check("wrap_1_rco_L", int'(u_bus.rco_L), 1);
        tick();
        check("wrap_0",       int'(u_bus.count), 0);
        check("wrap_0_zero",  int'(u_bus.zero), 1);
        check("wrap_0_rco_L", int'(u_bus.rco_L), 0);
        tick();
        check("wrap_5",       int'(u_bus.count), 5);
        check("wrap_5_rco_L", int'(u_bus.rco_L), 1);
        tick();
        check("wrap_4",       int'(u_bus.count), 4);

        // Hold at zero
        u_bus.hold = 1'b1;
        do_load(2);
        check("hold_2", int'(u_bus.count), 2);
        tick();
        check("hold_1", int'(u_bus.count), 1);
        tick();
        check("hold_0a",       int'(u_bus.count), 0);
        check("hold_0a_rco_L", int'(u_bus.rco_L), 0);
`ifdef COUNTER_DOWN_MOD_DONE_EN
        check("hold_done_pulse", int'(u_bus.done), 1);
`endif
        tick();
        check("hold_0b",       int'(u_bus.count), 0);
        check("hold_0b_rco_L", int'(u_bus.rco_L), 0);
`ifdef COUNTER_DOWN_MOD_DONE_EN
        check("hold_done_clear", int'(u_bus.done), 0);
`endif
        tick();
        check("hold_0c", int'(u_bus.count), 0);

        // Load beats wrap on the same edge; borrow still low before it
        u_bus.hold = 1'b0;
        u_bus.in   = 4'b0001;
        u_bus.load = 1'b1;
        #1;
        check("prio_rco_L", int'(u_bus.rco_L), 0);
        tick();
        u_bus.load    = 1'b0;
        u_bus.enablen = 1'b1;
        check("prio_count", int'(u_bus.count), 1);

        // Cascade mod-60
        u_lo_bus.in      = '0;
        u_hi_bus.in      = '0;
        u_lo_bus.load    = 1'b1;
        u_hi_bus.load    = 1'b1;
        u_lo_bus.enablen = 1'b0;
        tick();
        u_lo_bus.load = 1'b0;
        u_hi_bus.load = 1'b0;
        check("cas_00", 10 * int'(u_hi_bus.count) + int'(u_lo_bus.count), 0);
        tick();
        check("cas_59", 10 * int'(u_hi_bus.count) + int'(u_lo_bus.count), 59);
        repeat (9) tick();
        check("cas_50", 10 * int'(u_hi_bus.count) + int'(u_lo_bus.count), 50);
        tick();
        check("cas_49_hi", int'(u_hi_bus.count), 4);
        check("cas_49_lo", int'(u_lo_bus.count), 9);
        repeat (15) tick();
        u_lo_bus.enablen = 1'b1;
        tick();

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
